mem_arbiter: RTL
================

# mem_arbiter

Two-port to one-port memory arbiter for the pipelined MIPS core. It lets the instruction-fetch port and the data (load/store) port share one single-ported unified memory that answers with a variable-latency acknowledge. Each requester sees a request/ready handshake that the pipeline uses as a stall source. A watchdog counter ends any access the memory never acknowledges and flags an error.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent in ACCESS waiting for mem_ack before the access is aborted; legal range 1..255.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an aborted access.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held high until and including the if_ready cycle.
- if_addr  in  32  fetch byte address; stable while if_req is high.
- if_rdata  out  32  fetched instruction; registered; valid while if_ready is high.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; same hold rule as if_req.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; registered; valid while d_ready is high.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory access strobe; high for the whole ACCESS state.
- mem_we  out  1  memory write enable; valid with mem_req.
- mem_addr  out  32  latched address of the granted port.
- mem_wdata  out  32  latched store data; 0 for fetches.
- mem_rdata  in  32  memory read data; sampled in the cycle mem_ack is high.
- mem_ack  in  1  memory completion; only meaningful while mem_req is high.
- err  out  1  sticky; set on any timeout; cleared only by reset.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:**
  - If no request is pending, the FSM stays in IDLE.
  - If a request is pending, the arbiter picks a winner, latches that port's address, we and wdata into the mem_* registers, records the grant (gnt_d), clears the wait counter and moves to ACCESS.
  - Fetch requests always drive mem_we = 0.
- **ACCESS:**
  - mem_req = 1.
  - The wait counter increments every cycle mem_ack is low.
  - If mem_ack = 1, the arbiter captures mem_rdata into the granted port's rdata register (stores capture 0) and moves to RESP.
  - Otherwise, if the counter equals TIMEOUT - 1, the arbiter loads ERR_DATA into the granted port's rdata register, sets err and moves to RESP.
- **RESP:**
  - The granted port's ready is 1 for exactly one cycle, then the FSM returns to IDLE.
  - Requests are ignored in RESP, so a requester that is still holding req in its ready cycle is not re-granted.
- The rdata registers hold their last value until the next completion on the same port.
- The non-granted requester simply waits. Its ready stays 0, which stalls its pipeline stage.
- **Arbitration without the macro:** fixed priority, data over fetch, because the older instruction is in the MEM stage.
- **Reset:**
  - Forces IDLE and clears mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, err and the wait counter to 0.
  - If reset arrives during ACCESS, the access is abandoned with no ready pulse. The memory must tolerate mem_req dropping.

## Timing
- Request seen high at edge E0 while in IDLE → mem_req high from E0 for the following cycle (cycle 1).
- mem_ack high in cycle k (k ≥ 1) → ready high in cycle k+1.
- Minimum round trip is 2 cycles from request sample to ready. A back-to-back grant cannot occur earlier than the cycle after ready.
- Maximum ACCESS duration is TIMEOUT cycles. A timed-out access therefore shows ready TIMEOUT+1 cycles after the request was granted.
- A mem_ack that arrives in the same cycle as the counter hits its limit counts as success: ack wins and err is not set.
- mem_ack outside ACCESS is ignored.
- All outputs are registered. No input reaches an output combinationally.

## Configuration
- **MEM_ARB_RR_EN defined:** round-robin on ties.
  - A last-grant register resets to "fetch", so the first tie goes to data.
  - Each later tie goes to the port not granted last.
  - A lone requester is always granted and updates last-grant.
- **MEM_ARB_RR_EN undefined:** fixed data priority as described above. The last-grant register is not built.

## Test plan
- **Reset values:** assert reset for 2 cycles with if_req = d_req = 1 → all outputs 0, mem_req stays 0 during reset and goes high the cycle after release.
- **Single fetch:** if_req with if_addr = 0x40; memory acks 3 cycles after mem_req rises with mem_rdata = 0x2002_0005 → if_rdata = 0x2002_0005 and if_ready pulses exactly one cycle; mem_we = 0 throughout.
- **Tie:** if_req and d_req both held; store to 0x54 with wdata 7; ack after 1 cycle each.
  - Without the macro: the store is granted first (mem_we = 1, mem_wdata = 7), then the fetch, with one idle cycle between accesses.
  - With the macro: two ties in a row grant data then fetch, then data again.
- **Timeout:** TIMEOUT = 4, load from 0x10, mem_ack held at 0 → mem_req high for exactly 4 cycles, d_rdata = 0xDEAD_BEEF, d_ready pulses once, err = 1 and stays 1 until reset.
- **Ack on the limit cycle:** mem_ack rises in the 4th ACCESS cycle with TIMEOUT = 4 → normal data is returned and err stays 0.
- **Reset mid-access:** reset in the 2nd ACCESS cycle → no ready pulse, FSM in IDLE, and a request held after reset is re-granted cleanly.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data (load/store) port. Each access runs
// through IDLE -> ACCESS -> RESP. A watchdog aborts an access that the
// memory never acknowledges, returns ERR_DATA and raises a sticky err flag.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties). When it is
// undefined, data always wins over fetch.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Last ACCESS cycle before the watchdog fires (counter starts at 0).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;              // 1 = data port owns the access
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;
    logic        pick_data;
    logic [31:0] rsp_data;

`ifdef MEM_ARB_RR_EN
    logic        last_q, last_d;            // 1 = data was granted last

    // Tie goes to the port that did not win last time.
    always_comb begin
        pick_data = d_req && (!if_req || !last_q);
    end
`else
    // Fixed priority: the data port holds the older instruction.
    always_comb begin
        pick_data = d_req;
    end
`endif

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    // Next-state logic: grant in IDLE, wait for ack or watchdog in ACCESS,
    // one-cycle ready pulse in RESP.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        rsp_data    = '0;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    gnt_d       = pick_data;
                    mem_addr_d  = pick_data ? d_addr : if_addr;
                    mem_we_d    = pick_data && d_we;
                    mem_wdata_d = pick_data ? d_wdata : '0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    state_d     = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_d      = pick_data;
`endif
                end
            end
            ACCESS: begin
                // Ack is checked first so an ack on the limit cycle succeeds.
                if (mem_ack) begin
                    rsp_data  = mem_we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (gnt_q) begin
                        d_rdata_d = rsp_data;
                        d_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = rsp_data;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = RESP;
                        if (gnt_q) begin
                            d_rdata_d = ERR_DATA;
                            d_ready_d = 1'b1;
                        end else begin
                            if_rdata_d = ERR_DATA;
                            if_ready_d = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule
